// File: rtl/loader_pkg.sv
// Shared types and byte codes for the UART boot loader: FSM states, command and status bytes.
// Pure declarations; the status helper is combinational.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, COUNT, DATA, CSUM, RESP} state_e;

  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_RUN      = 8'h02;
  localparam logic [7:0] CMD_HOLD     = 8'h03;
  localparam logic [7:0] RSP_OK       = 8'h4B;
  localparam logic [7:0] RSP_CSUM     = 8'h45;
  localparam logic [7:0] RSP_UNKNOWN  = 8'h3F;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // A checksum error outranks an unknown command.
  function automatic logic [7:0] resp_status(input logic csum_ok, input logic [7:0] cmd);
    if (!csum_ok) return RSP_CSUM;
    if (cmd == CMD_WRITE || cmd == CMD_RUN || cmd == CMD_HOLD) return RSP_OK;
    return RSP_UNKNOWN;
  endfunction

endpackage

// File: rtl/uart_program_loader.sv
// Frame parser from the rx byte stream into the instr-mem write port; one status byte per frame.
// Write strobe one cycle after a word's last byte; rx stalls only while the status byte awaits i_tx_ready.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_mem_en,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wrdata,
  output logic        o_cpu_rst
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [15:0]   wcnt_q, wcnt_d;
  logic [15:0]   count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] to_q, to_d;
  logic          rx_ready_q, rx_ready_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          mem_en_q, mem_en_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wrdata_q, mem_wrdata_d;
  logic          cpu_rst_q, cpu_rst_d;

  logic          accept;
  logic [7:0]    csum_sum;
  logic [31:0]   shift_nx;
  logic [7:0]    status;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      shift_q      <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      csum_q       <= '0;
      to_q         <= '0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      shift_q      <= shift_d;
      bcnt_q       <= bcnt_d;
      wcnt_q       <= wcnt_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      to_q         <= to_d;
      rx_ready_q   <= rx_ready_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    shift_d      = shift_q;
    bcnt_d       = bcnt_q;
    wcnt_d       = wcnt_q;
    count_d      = count_q;
    addr_d       = addr_q;
    csum_d       = csum_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 4'h0;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;
    cpu_rst_d    = cpu_rst_q;

    accept   = i_rx_valid && rx_ready_q;
    csum_sum = csum_q + i_rx_data;
    shift_nx = {i_rx_data, shift_q[31:8]};
    status   = resp_status(csum_sum == 8'h00, cmd_q);
    to_d     = (state_q == IDLE || state_q == RESP || accept) ? '0 : to_q + 1'b1;

    case (state_q)
      IDLE: if (accept && i_rx_data == SYNC_BYTE) begin
        state_d = CMD;
        csum_d  = '0;
        bcnt_d  = '0;
        wcnt_d  = '0;
      end
      CMD: if (accept) begin
        cmd_d   = i_rx_data;
        csum_d  = csum_sum;
        state_d = ADDR;
      end
      ADDR: if (accept) begin
        shift_d = shift_nx;
        csum_d  = csum_sum;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          addr_d  = {shift_nx[31:2], 2'b00};
          state_d = COUNT;
        end
      end
      COUNT: if (accept) begin
        shift_d = shift_nx;
        csum_d  = csum_sum;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd1) begin
          count_d = shift_nx[31:16];
          bcnt_d  = '0;
          state_d = (shift_nx[31:16] != 16'd0) ? DATA : CSUM;
        end
      end
      DATA: if (accept) begin
        shift_d = shift_nx;
        csum_d  = csum_sum;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          wcnt_d = wcnt_q + 16'd1;
          if (cmd_q == CMD_WRITE) begin
            mem_en_d     = 1'b1;
            mem_we_d     = 4'hF;
            mem_addr_d   = addr_q;
            mem_wrdata_d = shift_nx;
            addr_d       = addr_q + 32'd4;
          end
          if (wcnt_q + 16'd1 == count_q) state_d = CSUM;
        end
      end
      CSUM: if (accept) begin
        tx_data_d  = status;
        tx_valid_d = 1'b1;
        state_d    = RESP;
        if (status == RSP_OK && cmd_q == CMD_RUN)  cpu_rst_d = 1'b0;
        if (status == RSP_OK && cmd_q == CMD_HOLD) cpu_rst_d = 1'b1;
      end
      RESP: if (i_tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abandon a stalled frame silently; partial writes already issued stand.
    if (state_q != IDLE && state_q != RESP && !accept && to_q == TW'(TIMEOUT_CYCLES - 1))
      state_d = IDLE;

    rx_ready_d = (state_d != RESP);
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_tx_data    = tx_data_q;
  assign o_mem_en     = mem_en_q;
  assign o_mem_we     = mem_we_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_wrdata = mem_wrdata_q;
  assign o_cpu_rst    = cpu_rst_q;

endmodule
